// File: rtl/demux_1to4_buf.sv
// demux_1to4_buf: steers one valid/ready input stream to one of four
// output channels. Each channel owns a one-entry holding register, so the
// four consumers drain independently of each other.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_data    input word (W bits)
//   in_valid   in_data is valid this cycle
//   in_ready   block accepts in_data this cycle (combinational)
//   s          channel select, used only on an accepted transfer
//   out_data   channel i word at bits [i*W +: W]
//   out_valid  channel i holding register is full
//   out_ready  consumer i takes its word this cycle
//   cur_sel    effective select currently in use (combinational)
//
// Build option:
//   DEMUX_AUTO_SEL_EN  when defined, s is ignored and an internal 2-bit
//                      round-robin pointer picks the channel, advancing on
//                      every accepted word.

module demux_1to4_buf #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     s,
  output logic [4*W-1:0] out_data,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [1:0]     cur_sel
);

  localparam int unsigned NCH = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e    state_q [NCH];
  ch_state_e    state_d [NCH];
  logic [W-1:0] data_q  [NCH];
  logic [W-1:0] data_d  [NCH];

  logic [1:0]   sel;
  logic         accept;

`ifdef DEMUX_AUTO_SEL_EN
  // Round-robin pointer; blocks on a full channel because it only moves on accept.
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic       unused_s;

  assign unused_s = ^s;
  assign sel      = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign sel = s;
`endif

  assign cur_sel = sel;

  // A full selected channel can still take a word if it is popped this cycle.
  assign in_ready = ~rst & (~out_valid[sel] | out_ready[sel]);
  assign accept   = in_valid & in_ready;

  // Per-channel next state: load wins over pop, giving 1 word/cycle streaming.
  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      state_d[i] = state_q[i];
      data_d[i]  = data_q[i];
      if (accept && (sel == 2'(i))) begin
        data_d[i] = in_data;
      end
      case (state_q[i])
        EMPTY: begin
          if (accept && (sel == 2'(i))) begin
            state_d[i] = FULL;
          end
        end
        FULL: begin
          if (out_ready[i] && !(accept && (sel == 2'(i)))) begin
            state_d[i] = EMPTY;
          end
        end
        default: state_d[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NCH); i++) begin
        state_q[i] <= EMPTY;
        data_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
      end
    end
  end

  for (genvar g = 0; g < int'(NCH); g++) begin : g_out
    assign out_valid[g]          = (state_q[g] == FULL);
    assign out_data[g*W +: W]    = data_q[g];
  end

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Scoreboard bench for demux_1to4_buf: the driver pushes every word it
// expects to be accepted onto the queue of its destination channel; the
// monitor compares each channel's visible state and word against the
// queue head and retires it when the consumer pops.

module tb_demux_1to4_buf;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     s;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [1:0]     cur_sel;

  always #5 clk = ~clk;

  demux_1to4_buf #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cur_sel   (cur_sel)
  );

  // Reference model: one queue of expected words per channel (depth <= 1),
  // a "loaded since reset" flag per channel and the round-robin pointer.
  logic [W-1:0] exp_q [4][$];
  bit           loaded [4];
  int           ptr;
  int           checks;
  int           errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(exp_q[i].size() != 0));
        if (exp_q[i].size() != 0) begin
          check($sformatf("out_data[%0d]", i), 32'(out_data[i*W +: W]), 32'(exp_q[i][0]));
          if (out_ready[i]) begin
            void'(exp_q[i].pop_front());
          end
        end else if (!loaded[i]) begin
          check($sformatf("idle_data[%0d]", i), 32'(out_data[i*W +: W]), 32'd0);
        end
      end
    end
  end

  // Driver: one clock cycle of stimulus; checks the handshake and records accepts.
  task automatic cyc(input bit r, input logic [1:0] sv, input bit v,
                     input logic [W-1:0] d, input logic [3:0] ordy);
    int  sel_e;
    bit  rdy_e;
    @(negedge clk);
    rst       = r;
    s         = sv;
    in_valid  = v;
    in_data   = d;
    out_ready = r ? 4'b0000 : ordy;
    #2;
`ifdef DEMUX_AUTO_SEL_EN
    sel_e = ptr;
`else
    sel_e = int'(sv);
`endif
    check("cur_sel", 32'(cur_sel), 32'(sel_e));
    // Monitor has already retired this cycle's pop, so a free slot means ready.
    rdy_e = !r && (exp_q[sel_e].size() == 0);
    check("in_ready", 32'(in_ready), 32'(rdy_e));
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[i].delete();
        loaded[i] = 1'b0;
      end
      ptr = 0;
    end else if (v && rdy_e) begin
      exp_q[sel_e].push_back(d);
      loaded[sel_e] = 1'b1;
      ptr = (ptr + 1) % 4;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    ptr       = 0;
    rst       = 1'b1;
    s         = 2'd0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 4'b0000;

    // Reset for two cycles, then idle with all channels empty.
    cyc(1'b1, 2'd0, 1'b0, 8'h00, 4'b0000);
    cyc(1'b1, 2'd0, 1'b0, 8'h00, 4'b0000);
    cyc(1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);

    // Steering to channel 2.
    cyc(1'b0, 2'd2, 1'b1, 8'hA5, 4'b0000);
    cyc(1'b0, 2'd0, 1'b0, 8'h00, 4'b0000);

    // Backpressure on channel 1, then release with same-cycle pop and load.
    cyc(1'b0, 2'd1, 1'b1, 8'h11, 4'b0000);
    cyc(1'b0, 2'd1, 1'b1, 8'h22, 4'b0000);
    cyc(1'b0, 2'd1, 1'b1, 8'h22, 4'b0000);
    cyc(1'b0, 2'd1, 1'b1, 8'h22, 4'b0010);
    cyc(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
    cyc(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);

    // Streaming on channel 0 with the consumer always ready.
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 2'd0, 1'b1, 8'(k), 4'b0001);
    end
    cyc(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);

    // Reset with words buffered.
    cyc(1'b0, 2'd0, 1'b1, 8'hAA, 4'b0000);
    cyc(1'b0, 2'd3, 1'b1, 8'hBB, 4'b0000);
    cyc(1'b1, 2'd0, 1'b1, 8'hCC, 4'b1111);
    cyc(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);

    // Six words with s held at 3 and every consumer ready.
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 2'd3, 1'b1, 8'(8'h10 + k), 4'b1111);
    end
    cyc(1'b0, 2'd3, 1'b0, 8'h00, 4'b1111);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 149) == 0),
          2'($urandom_range(0, 3)),
          ($urandom_range(0, 9) < 7),
          8'($urandom),
          4'($urandom));
    end

    // Drain.
    for (int n = 0; n < 4; n++) begin
      cyc(1'b0, 2'd0, 1'b0, 8'h00, 4'b1111);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1to4_buf.md
Name: demux_1to4_buf

Overview:
- 1-to-4 demultiplexer: steers a single valid/ready input stream to one of four output channels.
- Each output channel has a one-entry holding register, so each channel drains independently.
- Paired with the 4-to-1 mux as the fan-out end of the same 4-lane datapath.
- Sits between a single producer and four lane consumers.

Parameters:
W, 8, data width of input word and of each output channel.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_data  input  W  input word.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block accepts in_data this cycle.
s  input  2  channel select; sampled only on an accepted transfer.
out_data  output  4*W  channel i word at bits [i*W +: W].
out_valid  output  4  channel i holding register is full.
out_ready  input  4  consumer i takes its word this cycle.
cur_sel  output  2  effective select currently in use.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - While rst=1 at a rising edge: out_valid=4'b0000, all out_data=0, internal pointer=0 (feature only).
  - in_ready is forced to 0 in any cycle where rst=1.
- Effective select: sel = s (feature off) or pointer (feature on). cur_sel = sel, combinational.
- in_ready = ~out_valid[sel] | out_ready[sel]. Combinational; depends on the selected channel only.
- Accept = in_valid & in_ready.
  - On accept, at the next edge: out_data[sel] <= in_data and out_valid[sel] <= 1.
  - Latency from accept to out_valid is 1 cycle.
- Pop on channel i = out_valid[i] & out_ready[i]. On pop with no load into i in the same cycle, out_valid[i] <= 0.
  - out_data[i] keeps its old value after a pop and is don't-care.
- Simultaneous pop and load on the same channel: new word is loaded, out_valid stays 1. Full throughput, 1 word/cycle.
- Pop on channel j while loading channel i≠j: both happen independently.
- Per-channel state machine, 2 states:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on pop without load.
  - FULL -> FULL on pop with load, or on no pop (holding).
  - EMPTY ignores out_ready.
- Stability: while out_valid[i]=1 and out_ready[i]=0, out_data[i] holds its value.
- Full selected channel with no pop: in_ready=0. Nothing is accepted or dropped. The producer must hold its word.
- Changes on s while in_valid=1 and in_ready=0 are legal; the new value is re-evaluated the next cycle.
- in_valid=0: no state change except pops.
- Reset mid-operation: all buffered words are discarded and no pop is signalled.
  - The first accept after rst deasserts can happen in the first cycle with rst=0.
- No X on outputs after reset; out_data of an EMPTY channel is 0 until its first load.

Optional Feature:
DEMUX_AUTO_SEL_EN
- Defined:
  - s is ignored.
  - Internal 2-bit pointer selects the channel; reset value 0.
  - Pointer advances on every accept: 0->1->2->3->0, wrapping modulo 4.
  - Pointer does not advance while in_ready=0 (strict round-robin; it blocks on a full channel).
- Not defined:
  - sel = s, and no pointer register exists.
- cur_sel reflects the active select in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles -> out_valid=0000, out_data=0, in_ready=0. After release with all channels empty -> in_ready=1.
- Steering: s=2, in_data=8'hA5, in_valid=1 for 1 cycle, out_ready=0000 -> next cycle out_valid=0100, out_data[23:16]=A5. Other channels unchanged.
- Backpressure:
  - Channel 1 FULL (8'h11), out_ready[1]=0; drive s=1, in_data=8'h22, in_valid=1 -> in_ready=0, channel 1 still holds 11.
  - Raise out_ready[1] -> same cycle in_ready=1; next edge out_data[15:8]=22, out_valid[1]=1.
- Streaming: s=0, out_ready[0]=1, 5 consecutive words 01..05 -> out_valid[0]=1 on 5 consecutive cycles with 01..05 in order. No stall.
- Reset mid-operation: channels 0 and 3 FULL; assert rst one cycle -> out_valid=0000 next edge; buffered data not seen on any port.
- DEMUX_AUTO_SEL_EN build: 6 accepted words 10..15 with s=3 held, out_ready=1111 -> words land on channels 0,1,2,3,0,1. cur_sel sequence 0,1,2,3,0,1,2.
